// File: rtl/mul_seq_pkg.sv
// ==== mul_seq_pkg : shared types and constants for the shift-add multiply sequencer (rev 1.0) ====
`default_nettype none

package mul_seq_pkg;

   localparam int c_DATA_W   = 32;
   localparam int c_MUL_ITER = 32;
   localparam int c_CNT_W    = $clog2(c_MUL_ITER);
   localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(c_MUL_ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_NEG_A  = 3'd1,
      S_NEG_B  = 3'd2,
      S_MUL    = 3'd3,
      S_NEG_LO = 3'd4,
      S_NEG_HI = 3'd5,
      S_DONE   = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_seq.sv
// ==== mul_seq : 32x32->64 shift-add multiplier time-sharing the core adder (rev 1.0) ====
`default_nettype none

module mul_seq
   import mul_seq_pkg::*;
#(
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Start,
   input  logic                Signed,
   input  logic [c_DATA_W-1:0] OpA,
   input  logic [c_DATA_W-1:0] OpB,
   output logic                Ready,
   output logic                Done,
   output logic [c_DATA_W-1:0] ProdHi,
   output logic [c_DATA_W-1:0] ProdLo,
   output logic [c_DATA_W-1:0] AddA,
   output logic [c_DATA_W-1:0] AddB,
   input  logic [c_DATA_W-1:0] AddResult,
   input  logic                AddCout
);

   state_t               r_state;
   state_t               w_next;
   logic [c_DATA_W-1:0]  r_mc;
   logic [c_DATA_W-1:0]  r_hi;
   logic [c_DATA_W-1:0]  r_lo;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_sgn_a;
   logic                 r_sgn_b;
   logic                 r_neg_flag;
   logic                 r_carry;
   logic                 r_signed_path;
   logic [c_DATA_W-1:0]  r_prod_hi;
   logic [c_DATA_W-1:0]  r_prod_lo;
   logic                 r_done;
   logic [c_DATA_W-1:0]  w_add_a;
   logic [c_DATA_W-1:0]  w_add_b;
   logic                 w_ready;
   logic                 w_signed_req;
   logic                 w_neg;

   assign w_signed_req = Signed & SIGNED_EN;
   assign w_neg        = r_sgn_a ^ r_sgn_b;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_add_a = '0;
      w_add_b = '0;
      w_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (Start) begin
               w_next = w_signed_req ? S_NEG_A : S_MUL;
            end
         end
         S_NEG_A: begin
            w_add_a = ~r_mc;
            w_add_b = c_DATA_W'(1);
            w_next  = S_NEG_B;
         end
         S_NEG_B: begin
            w_add_a = ~r_lo;
            w_add_b = c_DATA_W'(1);
            w_next  = S_MUL;
         end
         S_MUL: begin
            w_add_a = r_hi;
            w_add_b = r_lo[0] ? r_mc : '0;
            if (r_cnt == c_LAST_ITER) begin
               w_next = r_signed_path ? S_NEG_LO : S_DONE;
            end
         end
         S_NEG_LO: begin
            w_add_a = ~r_lo;
            w_add_b = c_DATA_W'(1);
            w_next  = S_NEG_HI;
         end
         S_NEG_HI: begin
            // Upper half of the 64-bit negate: only the carry out of the low half is added.
            w_add_a = ~r_hi;
            w_add_b = {{(c_DATA_W-1){1'b0}}, r_carry};
            w_next  = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_mc          <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_cnt         <= '0;
         r_sgn_a       <= 1'b0;
         r_sgn_b       <= 1'b0;
         r_neg_flag    <= 1'b0;
         r_carry       <= 1'b0;
         r_signed_path <= 1'b0;
         r_prod_hi     <= '0;
         r_prod_lo     <= '0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_mc          <= OpA;
                  r_lo          <= OpB;
                  r_hi          <= '0;
                  r_cnt         <= '0;
                  r_sgn_a       <= OpA[c_DATA_W-1] & w_signed_req;
                  r_sgn_b       <= OpB[c_DATA_W-1] & w_signed_req;
                  r_signed_path <= w_signed_req;
                  r_neg_flag    <= 1'b0;
                  r_carry       <= 1'b0;
               end
            end
            S_NEG_A: begin
               if (r_sgn_a) r_mc <= AddResult;
            end
            S_NEG_B: begin
               if (r_sgn_b) r_lo <= AddResult;
            end
            S_MUL: begin
               // {Hi,Lo} shifts right by one with the adder's carry entering at the top.
               r_hi  <= {AddCout, AddResult[c_DATA_W-1:1]};
               r_lo  <= {AddResult[0], r_lo[c_DATA_W-1:1]};
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
            S_NEG_LO: begin
               r_neg_flag <= w_neg;
               if (w_neg) begin
                  r_lo    <= AddResult;
                  r_carry <= AddCout;
               end
            end
            S_NEG_HI: begin
               if (r_neg_flag) r_hi <= AddResult;
            end
            S_DONE: begin
               r_prod_hi <= r_hi;
               r_prod_lo <= r_lo;
               r_done    <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign Ready  = w_ready;
   assign Done   = r_done;
   assign ProdHi = r_prod_hi;
   assign ProdLo = r_prod_lo;
   assign AddA   = w_add_a;
   assign AddB   = w_add_b;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ==== tb_mul_seq : scoreboard bench for mul_seq, SIGNED_EN=1 and SIGNED_EN=0 side by side (rev 1.0) ====
`default_nettype none

module tb_mul_seq;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Start;
   logic        Signed;
   logic [31:0] OpA;
   logic [31:0] OpB;
   logic [1:0]  rdy;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          hold_mode = 1'b0;

   typedef struct {
      logic [63:0] prod;
      int          acc;
      int          lat;
   } exp_t;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, bit sgn);
      longint          sa, sb;
      longint unsigned ua, ub;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // u0 honours Signed, u1 is built with SIGNED_EN=0 and must ignore it.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam bit SEN = (gi == 0) ? 1'b1 : 1'b0;
      logic        w_rdy, w_done, w_cout;
      logic [31:0] w_ph, w_pl, w_aa, w_ab, w_res;
      exp_t        q[$];
      int          pend = 0;
      int          done_cnt = 0;
      int          last_acc = -1;
      logic        prev_done = 1'b0;

      assign {w_cout, w_res} = {1'b0, w_aa} + {1'b0, w_ab};
      assign rdy[gi] = w_rdy;

      mul_seq #(.SIGNED_EN(SEN)) u_dut (
         .Clk       (Clk),
         .Rst_n     (Rst_n),
         .Start     (Start),
         .Signed    (Signed),
         .OpA       (OpA),
         .OpB       (OpB),
         .Ready     (w_rdy),
         .Done      (w_done),
         .ProdHi    (w_ph),
         .ProdLo    (w_pl),
         .AddA      (w_aa),
         .AddB      (w_ab),
         .AddResult (w_res),
         .AddCout   (w_cout)
      );

      always @(posedge Clk) begin : b_accept
         exp_t e;
         bit   sp;
         if (!hold_mode) last_acc = -1;
         if (Rst_n && Start && w_rdy) begin
            sp     = Signed && SEN;
            e.prod = ref_mul(OpA, OpB, sp);
            e.acc  = cyc;
            e.lat  = sp ? 37 : 33;
            q.push_back(e);
            pend++;
            if (hold_mode && last_acc >= 0)
               check($sformatf("u%0d_accept_spacing", gi), 64'(cyc - last_acc), 64'd34);
            last_acc = cyc;
         end
      end

      always @(negedge Rst_n) begin
         q.delete();
         pend = 0;
      end

      always @(negedge Clk) begin : b_monitor
         exp_t e;
         if (Rst_n && w_done) begin
            done_cnt++;
            check($sformatf("u%0d_done_pulse_width", gi), 64'(prev_done), 64'd0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u%0d_unexpected_done: got Done=1 expected no pending op (t=%0t)", gi, $time);
            end else begin
               e = q.pop_front();
               pend--;
               check($sformatf("u%0d_product", gi), {w_ph, w_pl}, e.prod);
               check($sformatf("u%0d_latency", gi), 64'(cyc - e.acc - 1), 64'(e.lat));
            end
         end
         prev_done = Rst_n && w_done;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (rdy !== 2'b11 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (rdy !== 2'b11) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got Ready=%b expected 11", rdy);
      end
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] b, logic s);
      wait_ready();
      OpA    = a;
      OpB    = b;
      Signed = s;
      Start  = 1'b1;
      @(negedge Clk);
      Start  = 1'b0;
   endtask

   task automatic chk_idle(string tag, logic r, logic d, logic [31:0] ph, logic [31:0] pl,
                           logic [31:0] aa, logic [31:0] ab);
      check({tag, "_ready"}, 64'(r), 64'd1);
      check({tag, "_done"}, 64'(d), 64'd0);
      check({tag, "_prod"}, {ph, pl}, 64'd0);
      check({tag, "_adda"}, 64'(aa), 64'd0);
      check({tag, "_addb"}, 64'(ab), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          d0, d1, n;
      logic [31:0] a, b;
      Rst_n  = 1'b0;
      Start  = 1'b0;
      Signed = 1'b0;
      OpA    = '0;
      OpB    = '0;
      repeat (3) @(negedge Clk);
      chk_idle("rst_u0", g_dut[0].w_rdy, g_dut[0].w_done, g_dut[0].w_ph, g_dut[0].w_pl,
               g_dut[0].w_aa, g_dut[0].w_ab);
      chk_idle("rst_u1", g_dut[1].w_rdy, g_dut[1].w_done, g_dut[1].w_ph, g_dut[1].w_pl,
               g_dut[1].w_aa, g_dut[1].w_ab);
      Rst_n = 1'b1;
      @(negedge Clk);

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1);
      issue(32'h8000_0000, 32'h0000_0001, 1'b1);
      issue(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

      // Start pulse and operand churn while busy must not disturb the running op.
      issue($urandom, $urandom, 1'b1);
      repeat (5) @(negedge Clk);
      OpA    = $urandom;
      OpB    = $urandom;
      Signed = 1'b0;
      Start  = 1'b1;
      @(negedge Clk);
      Start  = 1'b0;

      wait_ready();
      OpA       = $urandom;
      OpB       = $urandom;
      Signed    = 1'b0;
      hold_mode = 1'b1;
      Start     = 1'b1;
      repeat (80) @(negedge Clk);
      Start     = 1'b0;
      hold_mode = 1'b0;

      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
         issue(a, b, 1'($urandom_range(0, 1)));
      end

      issue($urandom | 32'h8000_0000, $urandom, 1'b1);
      repeat (9) @(negedge Clk);
      d0    = g_dut[0].done_cnt;
      d1    = g_dut[1].done_cnt;
      Rst_n = 1'b0;
      #1;
      chk_idle("midrst_u0", g_dut[0].w_rdy, g_dut[0].w_done, g_dut[0].w_ph, g_dut[0].w_pl,
               g_dut[0].w_aa, g_dut[0].w_ab);
      chk_idle("midrst_u1", g_dut[1].w_rdy, g_dut[1].w_done, g_dut[1].w_ph, g_dut[1].w_pl,
               g_dut[1].w_aa, g_dut[1].w_ab);
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (45) @(negedge Clk);
      check("midrst_u0_no_done", 64'(g_dut[0].done_cnt), 64'(d0));
      check("midrst_u1_no_done", 64'(g_dut[1].done_cnt), 64'(d1));

      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

      n = 0;
      while ((g_dut[0].pend != 0 || g_dut[1].pend != 0) && n < 200) begin
         @(negedge Clk);
         n++;
      end
      check("drain_u0_pending", 64'(g_dut[0].pend), 64'd0);
      check("drain_u1_pending", 64'(g_dut[1].pend), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
